// File: rtl/lsu_byte_seq.sv
// ---------------------------------------------------------------------------
// lsu_byte_seq: splits RV32I loads/stores into little-endian byte accesses on
// the byte-wide memory port A and assembles/extends load results. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_byte_seq #(
   parameter int AW = 19
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [2:0]    req_funct3,
   input  logic [AW-1:0] req_addr,
   input  logic [31:0]   req_wdata,
   output logic          done,
   output logic          err,
   output logic [31:0]   rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wd,
   input  logic [7:0]    mem_rd
);

   localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RA   = 2'd2,
      RD   = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]    mem_wd_q, mem_wd_d;
   logic          mem_we_q, mem_we_d;
   logic [23:0]   wdata_q, wdata_d;
   logic [2:0]    funct3_q, funct3_d;
   logic [1:0]    idx_q, idx_d;
   logic [1:0]    last_q, last_d;
   logic [31:0]   asm_q, asm_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic          req_legal;
   logic [1:0]    req_last;
   logic [31:0]   asm_full;
   logic [31:0]   load_val;

   always_comb begin
      if (req_we) begin
         req_legal = (req_funct3[2] == 1'b0) && (req_funct3[1:0] != 2'b11);
      end else begin
         req_legal = (req_funct3[1:0] != 2'b11) && !(req_funct3[2] && req_funct3[1]);
      end
      case (req_funct3[1:0])
         2'b00:   req_last = 2'd0;
         2'b01:   req_last = 2'd1;
         default: req_last = 2'd3;
      endcase
   end

   // Assembly word including the byte arriving this cycle on mem_rd.
   always_comb begin
      asm_full = asm_q;
      asm_full[{idx_q, 3'b000} +: 8] = mem_rd;
      case (funct3_q)
         3'b000:  load_val = {{24{asm_full[7]}}, asm_full[7:0]};
         3'b001:  load_val = {{16{asm_full[15]}}, asm_full[15:0]};
         3'b100:  load_val = {24'h000000, asm_full[7:0]};
         3'b101:  load_val = {16'h0000, asm_full[15:0]};
         default: load_val = asm_full;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      mem_addr_d = mem_addr_q;
      mem_wd_d   = mem_wd_q;
      mem_we_d   = mem_we_q;
      wdata_d    = wdata_q;
      funct3_d   = funct3_q;
      idx_d      = idx_q;
      last_d     = last_q;
      asm_d      = asm_q;
      rdata_d    = rdata_q;
      done_d     = 1'b0;
      err_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               funct3_d = req_funct3;
               idx_d    = 2'd0;
               last_d   = req_last;
               if (!req_legal) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end else if (req_we) begin
                  state_d    = WR;
                  mem_we_d   = 1'b1;
                  mem_addr_d = req_addr;
                  mem_wd_d   = req_wdata[7:0];
                  wdata_d    = req_wdata[31:8];
               end else begin
                  state_d    = RA;
                  mem_addr_d = req_addr;
               end
            end
         end

         WR: begin
            if (idx_q == last_q) begin
               state_d  = IDLE;
               mem_we_d = 1'b0;
               done_d   = 1'b1;
            end else begin
               idx_d      = idx_q + 2'd1;
               mem_addr_d = mem_addr_q + ADDR_ONE;
               mem_wd_d   = wdata_q[7:0];
               wdata_d    = {8'h00, wdata_q[23:8]};
            end
         end

         // Address stays put for the data cycle: the memory's read mux is
         // steered by the upper address bits, so reads are never pipelined.
         RA: begin
            state_d = RD;
         end

         RD: begin
            asm_d = asm_full;
            if (idx_q == last_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
               rdata_d = load_val;
            end else begin
               state_d    = RA;
               idx_d      = idx_q + 2'd1;
               mem_addr_d = mem_addr_q + ADDR_ONE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         mem_addr_q <= '0;
         mem_wd_q   <= 8'h00;
         mem_we_q   <= 1'b0;
         wdata_q    <= 24'h000000;
         funct3_q   <= 3'b000;
         idx_q      <= 2'd0;
         last_q     <= 2'd0;
         asm_q      <= 32'h0000_0000;
         rdata_q    <= 32'h0000_0000;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         mem_addr_q <= mem_addr_d;
         mem_wd_q   <= mem_wd_d;
         mem_we_q   <= mem_we_d;
         wdata_q    <= wdata_d;
         funct3_q   <= funct3_d;
         idx_q      <= idx_d;
         last_q     <= last_d;
         asm_q      <= asm_d;
         rdata_q    <= rdata_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign done      = done_q;
   assign err       = err_q;
   assign rdata     = rdata_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wd    = mem_wd_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_byte_seq.sv
// ---------------------------------------------------------------------------
// tb_lsu_byte_seq: self-checking bench for lsu_byte_seq with a byte-array
// memory on port A and a behavioural load/store reference model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lsu_byte_seq;

   localparam int AW       = 19;
   localparam int MEM_SIZE = 1 << AW;

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [2:0]    req_funct3;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          done;
   logic          err;
   logic [31:0]   rdata;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wd;
   logic [7:0]    mem_rd;

   logic [7:0]    port_mem [0:MEM_SIZE-1];
   logic [7:0]    ref_mem  [0:MEM_SIZE-1];

   int            checks;
   int            errors;
   logic [31:0]   exp_rd_hold;

   typedef struct {
      bit        we;
      bit [2:0]  f3;
      bit [18:0] addr;
      bit [31:0] wdata;
      int        exp_done;
      bit        exp_err;
      bit [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [14];

   lsu_byte_seq #(.AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .done       (done),
      .err        (err),
      .rdata      (rdata),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Port A: synchronous read, data valid the cycle after the address.
   always @(posedge clk) begin
      if (mem_we) port_mem[mem_addr] <= mem_wd;
      mem_rd <= port_mem[mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_legal(input bit we, input bit [2:0] f3);
      if (we) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
   endfunction

   function automatic int nbytes(input bit [2:0] f3);
      if (f3[1:0] == 2'd0) return 1;
      if (f3[1:0] == 2'd1) return 2;
      return 4;
   endfunction

   // Little-endian value of N bytes, then two's-complement reinterpretation for signed loads.
   function automatic logic [31:0] model_load(input bit [2:0] f3, input bit [18:0] a);
      longint v = 0;
      int     n = nbytes(f3);
      for (int k = 0; k < n; k++)
         v += longint'(ref_mem[(int'(a) + k) % MEM_SIZE]) << (8 * k);
      if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
         v -= (longint'(1) << (8 * n));
      return 32'(v);
   endfunction

   // Issues one request from an IDLE-aligned point (posedge+1) and follows it to done.
   task automatic do_req(input bit we, input bit [2:0] f3, input bit [18:0] a,
                         input bit [31:0] wd, output int got_cyc, output bit got_err,
                         output logic [31:0] got_rdata);
      bit          legal = is_legal(we, f3);
      int          n     = legal ? nbytes(f3) : 0;
      int          exp_c = !legal ? 1 : (we ? n + 1 : 2 * n + 1);
      logic [31:0] exp_r = (legal && !we) ? model_load(f3, a) : exp_rd_hold;
      bit          seen  = 1'b0;
      int          cyc;

      chk("ready_idle", 32'(req_ready), 32'd1);
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      req_valid  = 1'b1;
      @(posedge clk); #1;
      req_valid  = 1'b0;

      for (cyc = 1; cyc <= 12; cyc++) begin
         if (legal && we && cyc <= n) begin
            chk("store_we", 32'(mem_we), 32'd1);
            chk("store_addr", 32'(mem_addr), 32'((int'(a) + cyc - 1) % MEM_SIZE));
            chk("store_wd", 32'(mem_wd), 32'(wd[8 * (cyc - 1) +: 8]));
         end else begin
            chk("mem_we_low", 32'(mem_we), 32'd0);
         end
         if (legal && !we && cyc <= 2 * n)
            chk("load_addr", 32'(mem_addr), 32'((int'(a) + (cyc - 1) / 2) % MEM_SIZE));
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         chk("ready_busy", 32'(req_ready), 32'd0);
         @(posedge clk); #1;
      end

      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done expected done at cycle %0d", exp_c);
      end
      got_cyc   = cyc;
      got_err   = err;
      got_rdata = rdata;
      chk("done_cycle", 32'(cyc), 32'(exp_c));
      chk("err", 32'(err), 32'(!legal));
      chk("ready_done", 32'(req_ready), 32'd1);
      chk("rdata", rdata, exp_r);

      if (legal && we)
         for (int k = 0; k < n; k++) ref_mem[(int'(a) + k) % MEM_SIZE] = wd[8 * k +: 8];
      exp_rd_hold = exp_r;
   endtask

   initial begin
      int          g_cyc;
      bit          g_err;
      logic [31:0] g_rd;
      logic [31:0] old_word;
      logic [31:0] e1;
      logic [31:0] e2;
      bit [18:0]   a;
      bit [2:0]    f3;
      bit          we;
      bit [31:0]   wd;

      checks      = 0;
      errors      = 0;
      exp_rd_hold = 32'h0;
      rst_n       = 1'b0;
      req_valid   = 1'b0;
      req_we      = 1'b0;
      req_funct3  = 3'b000;
      req_addr    = '0;
      req_wdata   = 32'h0;
      for (int i = 0; i < MEM_SIZE; i++) begin
         port_mem[i] = 8'($urandom);
         ref_mem[i]  = port_mem[i];
      end

      vecs[0]  = '{1'b1, 3'd0, 19'h00010, 32'h0000_00A5, 2, 1'b0, 32'h0000_0000};
      vecs[1]  = '{1'b0, 3'd0, 19'h00010, 32'h0,         3, 1'b0, 32'hFFFF_FFA5};
      vecs[2]  = '{1'b0, 3'd4, 19'h00010, 32'h0,         3, 1'b0, 32'h0000_00A5};
      vecs[3]  = '{1'b1, 3'd2, 19'h007FE, 32'h1234_5678, 5, 1'b0, 32'h0000_00A5};
      vecs[4]  = '{1'b0, 3'd2, 19'h007FE, 32'h0,         9, 1'b0, 32'h1234_5678};
      vecs[5]  = '{1'b1, 3'd1, 19'h7FFFF, 32'hDEAD_8001, 3, 1'b0, 32'h1234_5678};
      vecs[6]  = '{1'b0, 3'd1, 19'h7FFFF, 32'h0,         5, 1'b0, 32'hFFFF_8001};
      vecs[7]  = '{1'b0, 3'd5, 19'h7FFFF, 32'h0,         5, 1'b0, 32'h0000_8001};
      vecs[8]  = '{1'b0, 3'd0, 19'h00000, 32'h0,         3, 1'b0, 32'hFFFF_FF80};
      vecs[9]  = '{1'b0, 3'd3, 19'h00010, 32'h0,         1, 1'b1, 32'hFFFF_FF80};
      vecs[10] = '{1'b1, 3'd4, 19'h00020, 32'h1122_3344, 1, 1'b1, 32'hFFFF_FF80};
      vecs[11] = '{1'b0, 3'd6, 19'h00010, 32'h0,         1, 1'b1, 32'hFFFF_FF80};
      vecs[12] = '{1'b1, 3'd3, 19'h00030, 32'h5566_7788, 1, 1'b1, 32'hFFFF_FF80};
      vecs[13] = '{1'b0, 3'd5, 19'h007FE, 32'h0,         5, 1'b0, 32'h0000_5678};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wd", 32'(mem_wd), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++) begin
         do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, g_cyc, g_err, g_rd);
         chk($sformatf("vec%0d_done", i), 32'(g_cyc), 32'(vecs[i].exp_done));
         chk($sformatf("vec%0d_err", i), 32'(g_err), 32'(vecs[i].exp_err));
         chk($sformatf("vec%0d_rdata", i), g_rd, vecs[i].exp_rdata);
      end

      // Back-to-back loads with req_valid held high across both.
      e1 = model_load(3'd2, 19'h007FE);
      e2 = model_load(3'd2, 19'h7FFFF);
      chk("b2b_ready0", 32'(req_ready), 32'd1);
      req_we     = 1'b0;
      req_funct3 = 3'd2;
      req_addr   = 19'h007FE;
      req_valid  = 1'b1;
      @(posedge clk); #1;
      req_addr = 19'h7FFFF;
      for (int c = 1; c <= 18; c++) begin
         if (c == 9 || c == 18) begin
            chk($sformatf("b2b_done_c%0d", c), 32'(done), 32'd1);
            chk($sformatf("b2b_ready_c%0d", c), 32'(req_ready), 32'd1);
            chk($sformatf("b2b_rdata_c%0d", c), rdata, (c == 9) ? e1 : e2);
            if (c == 18) req_valid = 1'b0;
         end else begin
            chk($sformatf("b2b_ready_c%0d", c), 32'(req_ready), 32'd0);
            chk($sformatf("b2b_done_c%0d", c), 32'(done), 32'd0);
         end
         if (c < 18) begin
            @(posedge clk); #1;
         end
      end
      exp_rd_hold = e2;
      @(posedge clk); #1;
      chk("b2b_no_third", 32'(done), 32'd0);

      // Reset during the second byte of a word store.
      a = 19'h00100;
      old_word = {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]};
      chk("rstsw_ready", 32'(req_ready), 32'd1);
      req_we     = 1'b1;
      req_funct3 = 3'd2;
      req_addr   = a;
      req_wdata  = 32'hCAFE_BABE;
      req_valid  = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rstsw_we_c1", 32'(mem_we), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rstsw_we_async", 32'(mem_we), 32'd0);
      chk("rstsw_ready_async", 32'(req_ready), 32'd1);
      repeat (2) begin
         @(posedge clk); #1;
         chk("rstsw_done_held", 32'(done), 32'd0);
         chk("rstsw_we_held", 32'(mem_we), 32'd0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rstsw_done_after", 32'(done), 32'd0);
      chk("rstsw_ready_after", 32'(req_ready), 32'd1);
      chk("rstsw_rdata_after", rdata, 32'd0);
      ref_mem[a]  = 8'hBE;
      exp_rd_hold = 32'h0;
      do_req(1'b0, 3'd2, a, 32'h0, g_cyc, g_err, g_rd);
      chk("rstsw_partial", g_rd, {old_word[31:8], 8'hBE});

      // Randomized traffic in small windows, two of them straddling wrap/block edges.
      for (int i = 0; i < 150; i++) begin
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 2))
            0:       a = 19'(32'h7FFF8 + $urandom_range(0, 7) * 2);
            1:       a = 19'(32'h007F8 + $urandom_range(0, 15));
            default: a = 19'($urandom_range(0, 31));
         endcase
         wd = $urandom;
         do_req(we, f3, a, wd, g_cyc, g_err, g_rd);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/lsu_byte_seq.md
# lsu_byte_seq

Load/store sequencer between the RV32I core and the byte-wide main-memory port (port A, 19-bit byte address, 8-bit data, synchronous read). It accepts one 8/16/32-bit load or store per request and breaks it into little-endian byte accesses on port A. For loads it assembles the bytes, sign- or zero-extends the result and returns a 32-bit word. It is the initiator side of port A and owns that port's `we`, `addr` and `wd` signals exclusively.

## Interface
- `AW`, 19: memory byte-address width; must match the port A address width.
- `clk`  in  1: system clock; all logic is rising-edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: sequencer can accept a request (high in IDLE).
- `req_we`  in  1: 1 = store, 0 = load.
- `req_funct3`  in  3: RV32I funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `req_addr`  in  AW: byte address; misaligned addresses are legal.
- `req_wdata`  in  32: store data; low bytes are used first.
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: pulses together with `done` when funct3 is illegal.
- `rdata`  out  32: load result. Valid when `done` is high; held until the next load completes.
- `mem_we`  out  1: port A write enable.
- `mem_addr`  out  AW: port A byte address.
- `mem_wd`  out  8: port A write data.
- `mem_rd`  in  8: port A read data, valid one cycle after the address is presented, provided `mem_addr` is held.

## Operation
- Request accept: a request is accepted on a rising edge where `req_valid & req_ready`. On accept, latch we, funct3, addr, wdata and set N = 1, 2 or 4 from funct3[1:0].
- Illegal funct3: loads with 011, 110 or 111, and stores with funct3 ≠ 000/001/010. No memory access is made; the next cycle has `done=1`, `err=1`, and `rdata` is unchanged.
- States:
  - IDLE: `req_ready=1`.
  - WR
  - RA (read address)
  - RD (read data)
- Store path: IDLE→WR. In WR, byte k = 0..N-1 uses one cycle each:
  - `mem_addr = addr+k` (mod 2^AW), `mem_we=1`, `mem_wd = wdata[8k+7:8k]`.
  - After byte N-1, return to IDLE with `done=1`.
- Load path: IDLE→RA→RD, alternating per byte.
  - RA: `mem_addr = addr+k`.
  - RD: `mem_addr` is held unchanged; `mem_rd` is captured into byte k of the assembly register.
  - After RD of byte N-1, go to IDLE with `done=1`.
  - Address is held through RD because the memory's read mux is selected by `addr[18:11]`. Pipelining across a 2 KiB block boundary would return wrong data, so every read takes two cycles.
- Load extension: LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW takes no extension.
- `mem_we` is 0 in every state except WR.
- `mem_addr` and `mem_wd` hold their last values in IDLE.
- Address wrap: `addr+k` wraps modulo 2^AW (0x7FFFF+1 → 0x00000).
- `req_valid` while busy is ignored. It is not queued, and the request is not dropped until it is accepted.

## Timing
- Reset values: state IDLE; `req_ready=1`, `done=0`, `err=0`, `rdata=0`, `mem_we=0`, `mem_addr=0`, `mem_wd=0`.
- Reset asserted mid-operation: the sequencer returns to IDLE immediately and asynchronously. `mem_we` drops in the same cycle. A partial store stays partially written. No `done` is issued for the aborted request.
- Cycle numbering: cycle 0 is the accept edge.
  - Store of N bytes: writes in cycles 1..N; `done` in cycle N+1. SW: `done` at cycle 5.
  - Load of N bytes: RA/RD pairs in cycles 1..2N; `done` in cycle 2N+1. LW: `done` at cycle 9; LB: `done` at cycle 3.
  - Illegal request: `done`+`err` at cycle 1.
- `done` and `req_ready` are both high in the completion cycle, so back-to-back requests are allowed with no bubble beyond that cycle.
- `rdata` updates on the edge that enters the completion cycle. It holds through stores and illegal requests.

## Test plan
- SB 0xA5 to 0x00010, then LB and LBU at 0x00010 → `rdata` 0xFFFFFFA5 then 0x000000A5. SB `done` at cycle 2; LB `done` at cycle 3.
- SW 0x12345678 at 0x007FE, crossing the 2 KiB block boundary, then LW 0x007FE → `mem_addr` 0x7FE..0x801 with `mem_wd` 78,56,34,12; `rdata` 0x12345678; LW `done` at cycle 9.
- SH 0x8001 at 0x7FFFF, then LH 0x7FFFF → bytes land at 0x7FFFF and 0x00000 (wrap); LH `rdata` 0xFFFF8001; LHU at the same address → 0x00008001.
- Load with funct3 011 → `done=1` and `err=1` at cycle 1; `mem_we` stays 0; `rdata` keeps its previous value.
- Reset asserted at cycle 2 of an SW → `mem_we` low within the same cycle, `done` never pulses, `req_ready=1` after release; LW then reads the first byte new and the remaining three bytes old.
- `req_valid` held high for two LW requests → second accept coincides with the first `done` cycle; `req_ready` is low during cycles 1..8 of each request.
